// File: rtl/uart_pkg.sv
// Shared types and helpers for the native UART transceiver with word packing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    // Rounded clock-cycles-per-bit divisor.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_fifo_buf.sv
// Synchronous show-ahead FIFO; a full FIFO still takes a write when the head pops in the same cycle.
module uart_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNTW-1:0]  count_r;
    logic [CNTW-1:0]  count_nxt_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             valid_r;
    logic             full_r;

    // Qualify push/pop against the registered flags and form the next occupancy.
    always_comb begin
        pop_ok_s    = pop & valid_r;
        push_ok_s   = push & (~full_r | pop_ok_s);
        count_nxt_s = count_r + CNTW'(push_ok_s) - CNTW'(pop_ok_s);
    end

    // Storage, pointers and flags that already reflect the post-edge state.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != '0);
            full_r  <= (count_nxt_s == CNTW'(DEPTH));
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign valid   = valid_r;
    assign full    = full_r;

endmodule

// File: rtl/uart_fifo.sv
// UART transceiver moving DATA_W-bit words as LSB-first bytes through RX/TX FIFOs.
// Define UART_PARITY_EN for even-parity framing (8E1); otherwise 8N1.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_wr,
    output logic              tx_full,
    output logic              tx_busy,
    output logic              frame_err,
    output logic              rx_overrun,
    input  logic              ovr_clr
);

    localparam int DIV       = baud_div(CLK_HZ, BAUD);
    localparam int HALF      = DIV / 2;
    localparam int CW        = $clog2(DIV);
    localparam int NBYTES    = DATA_W / 8;
    localparam int BW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int LAST_BYTE = NBYTES - 1;

    uart_state_e       rx_state_r, rx_state_nxt_s;
    logic              rx_meta_r, rx_sync_r, rx_prev_r;
    logic [CW-1:0]     rx_cnt_r;
    logic [2:0]        rx_bit_r;
    logic [7:0]        rx_shift_r;
    logic              rx_par_err_r;
    logic [BW-1:0]     rx_byte_r;
    logic [DATA_W-1:0] rx_word_r, rx_push_word_s;
    logic              rx_sample_s, rx_accept_s, rx_bad_s, rx_push_s;
    logic              rx_full_s, rx_pop_s, rx_ovr_set_s;
    logic              frame_err_r, rx_overrun_r;

    uart_state_e       tx_state_r, tx_state_nxt_s;
    logic [CW-1:0]     tx_cnt_r;
    logic [2:0]        tx_bit_r;
    logic [BW-1:0]     tx_byte_r;
    logic [DATA_W-1:0] tx_shift_r, tx_head_s;
    logic              tx_line_r, tx_tick_s, tx_last_s, tx_pop_s, tx_valid_s;

    // RX bit-timing strobe: mid-start after DIV/2, then once per DIV.
    always_comb begin
        if (rx_state_r == START) begin
            rx_sample_s = (rx_cnt_r == CW'(HALF - 1));
        end else if (rx_state_r == IDLE) begin
            rx_sample_s = 1'b0;
        end else begin
            rx_sample_s = (rx_cnt_r == CW'(DIV - 1));
        end
    end

    // RX state register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r <= IDLE;
        end else begin
            rx_state_r <= rx_state_nxt_s;
        end
    end

    // RX next state; a start that reads high at mid-bit is a glitch.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        case (rx_state_r)
            IDLE:  if (rx_prev_r & ~rx_sync_r) rx_state_nxt_s = START; else rx_state_nxt_s = IDLE;
            START: if (rx_sample_s) rx_state_nxt_s = rx_sync_r ? IDLE : DATA; else rx_state_nxt_s = START;
            DATA: begin
                if (rx_sample_s && rx_bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
                    rx_state_nxt_s = PAR;
`else
                    rx_state_nxt_s = STOP;
`endif
                end else begin
                    rx_state_nxt_s = DATA;
                end
            end
            PAR:   if (rx_sample_s) rx_state_nxt_s = STOP; else rx_state_nxt_s = PAR;
            STOP:  if (rx_sample_s) rx_state_nxt_s = IDLE; else rx_state_nxt_s = STOP;
            default: rx_state_nxt_s = IDLE;
        endcase
    end

    // RX outputs: stop-sample verdict and the word as it would look with this byte merged in.
    always_comb begin
        rx_push_word_s = rx_word_r;
        rx_push_word_s[{rx_byte_r, 3'b000} +: 8] = rx_shift_r;
        rx_bad_s    = 1'b0;
        rx_accept_s = 1'b0;
        if (rx_state_r == STOP && rx_sample_s) begin
            rx_bad_s    = ~rx_sync_r | rx_par_err_r;
            rx_accept_s = rx_sync_r & ~rx_par_err_r;
        end else begin
            rx_bad_s    = 1'b0;
            rx_accept_s = 1'b0;
        end
        rx_push_s    = rx_accept_s & (rx_byte_r == BW'(LAST_BYTE));
        rx_pop_s     = rx_valid & rx_ready;
        rx_ovr_set_s = rx_push_s & rx_full_s & ~rx_pop_s;
    end

    // RX datapath: synchroniser, bit timing, shift, packing and flags.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r    <= 1'b1;
            rx_sync_r    <= 1'b1;
            rx_prev_r    <= 1'b1;
            rx_cnt_r     <= '0;
            rx_bit_r     <= 3'd0;
            rx_shift_r   <= 8'h00;
            rx_par_err_r <= 1'b0;
            rx_byte_r    <= '0;
            rx_word_r    <= '0;
            frame_err_r  <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            if (rx_state_r == IDLE || rx_sample_s) begin
                rx_cnt_r <= '0;
            end else begin
                rx_cnt_r <= rx_cnt_r + CW'(1);
            end
            if (rx_state_r == START) begin
                rx_bit_r     <= 3'd0;
                rx_par_err_r <= 1'b0;
            end else if (rx_state_r == DATA && rx_sample_s) begin
                rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                rx_bit_r   <= rx_bit_r + 3'd1;
            end else if (rx_state_r == PAR && rx_sample_s) begin
                rx_par_err_r <= rx_sync_r ^ even_par(rx_shift_r);
            end
            if (rx_accept_s) begin
                rx_word_r <= rx_push_word_s;
                rx_byte_r <= rx_push_s ? '0 : rx_byte_r + BW'(1);
            end else if (rx_bad_s) begin
                rx_byte_r <= '0;
            end
            frame_err_r <= rx_bad_s;
            if (rx_ovr_set_s) begin
                rx_overrun_r <= 1'b1;
            end else if (ovr_clr) begin
                rx_overrun_r <= 1'b0;
            end
        end
    end

    uart_fifo_buf #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .push    (rx_push_s),
        .wr_data (rx_push_word_s),
        .pop     (rx_ready),
        .rd_data (rx_data),
        .valid   (rx_valid),
        .full    (rx_full_s)
    );

    uart_fifo_buf #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .push    (tx_wr),
        .wr_data (tx_data),
        .pop     (tx_pop_s),
        .rd_data (tx_head_s),
        .valid   (tx_valid_s),
        .full    (tx_full)
    );

    // TX bit-period strobe.
    always_comb begin
        if (tx_state_r != IDLE) begin
            tx_tick_s = (tx_cnt_r == CW'(DIV - 1));
        end else begin
            tx_tick_s = 1'b0;
        end
        tx_last_s = (tx_byte_r == BW'(LAST_BYTE));
    end

    // TX state register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= IDLE;
        end else begin
            tx_state_r <= tx_state_nxt_s;
        end
    end

    // TX next state; the next word follows the last stop bit with no idle gap.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        case (tx_state_r)
            IDLE:  if (tx_valid_s) tx_state_nxt_s = START; else tx_state_nxt_s = IDLE;
            START: if (tx_tick_s) tx_state_nxt_s = DATA; else tx_state_nxt_s = START;
            DATA: begin
                if (tx_tick_s && tx_bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
                    tx_state_nxt_s = PAR;
`else
                    tx_state_nxt_s = STOP;
`endif
                end else begin
                    tx_state_nxt_s = DATA;
                end
            end
            PAR:   if (tx_tick_s) tx_state_nxt_s = STOP; else tx_state_nxt_s = PAR;
            STOP: begin
                if (tx_tick_s && (!tx_last_s || tx_valid_s)) begin
                    tx_state_nxt_s = START;
                end else if (tx_tick_s) begin
                    tx_state_nxt_s = IDLE;
                end else begin
                    tx_state_nxt_s = STOP;
                end
            end
            default: tx_state_nxt_s = IDLE;
        endcase
    end

    // TX outputs: FIFO pop on word boundaries.
    always_comb begin
        if (tx_state_r == IDLE) begin
            tx_pop_s = tx_valid_s;
        end else if (tx_state_r == STOP) begin
            tx_pop_s = tx_tick_s & tx_last_s & tx_valid_s;
        end else begin
            tx_pop_s = 1'b0;
        end
    end

    // TX datapath; the line register follows the current state one cycle later.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_byte_r  <= '0;
            tx_shift_r <= '0;
            tx_line_r  <= 1'b1;
        end else begin
            if (tx_state_r == IDLE || tx_tick_s) begin
                tx_cnt_r <= '0;
            end else begin
                tx_cnt_r <= tx_cnt_r + CW'(1);
            end
            if (tx_state_r == START) begin
                tx_bit_r <= 3'd0;
            end else if (tx_state_r == DATA && tx_tick_s) begin
                tx_bit_r <= tx_bit_r + 3'd1;
            end
            if (tx_pop_s) begin
                tx_shift_r <= tx_head_s;
                tx_byte_r  <= '0;
            end else if (tx_state_r == STOP && tx_tick_s && !tx_last_s) begin
                tx_shift_r <= tx_shift_r >> 8;
                tx_byte_r  <= tx_byte_r + BW'(1);
            end
            case (tx_state_r)
                IDLE:    tx_line_r <= 1'b1;
                START:   tx_line_r <= 1'b0;
                DATA:    tx_line_r <= tx_shift_r[tx_bit_r];
                PAR:     tx_line_r <= even_par(tx_shift_r[7:0]);
                STOP:    tx_line_r <= 1'b1;
                default: tx_line_r <= 1'b1;
            endcase
        end
    end

    assign uart_tx    = tx_line_r;
    assign tx_busy    = tx_valid_s | (tx_state_r != IDLE);
    assign frame_err  = frame_err_r;
    assign rx_overrun = rx_overrun_r;

endmodule
